// File: rtl/cart_mbc1.sv
// +--------------------------------------------------------------------------+
// | Module      : cart_mbc1                                                   |
// | Description : MBC1 cartridge mapper for ROM/RAM banking, 1-cycle reads.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module cart_mbc1 #(
    parameter int ROM_ADDR_WIDTH = 21,
    parameter int RAM_ADDR_WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                cart_addr,
    input  logic                       cart_enable,
    input  logic                       cart_write,
    input  logic [7:0]                 cart_wdata,
    output logic [7:0]                 cart_rdata,
    output logic [ROM_ADDR_WIDTH-1:0]  rom_addr,
    output logic                       rom_read,
    input  logic [7:0]                 rom_data,
    output logic [((RAM_ADDR_WIDTH > 0) ? RAM_ADDR_WIDTH : 1)-1:0] ram_addr,
    output logic                       ram_read,
    output logic                       ram_write,
    output logic [7:0]                 ram_wdata,
    input  logic [7:0]                 ram_rdata,
    output logic                       save_dirty,
    input  logic                       save_ack
);

    localparam int         c_RAM_AW   = (RAM_ADDR_WIDTH > 0) ? RAM_ADDR_WIDTH : 1;
    localparam logic       c_HAS_RAM  = (RAM_ADDR_WIDTH > 0);
    localparam logic [2:0] c_SRC_NONE = 3'b001;
    localparam logic [2:0] c_SRC_ROM  = 3'b010;
    localparam logic [2:0] c_SRC_RAM  = 3'b100;

    logic       r_ram_en;
    logic [4:0] r_bank1;
    logic [1:0] r_bank2;
    logic       r_mode;
    logic       r_dirty;
    logic [2:0] r_src;
    logic [2:0] w_src_next;

    logic       w_rd;
    logic       w_wr;
    logic       w_rom_range;
    logic       w_ram_range;
    logic       w_ram_ok;
    logic [6:0] w_rom_bank;
    logic [1:0] w_ram_bank;
    logic [4:0] w_bank1_wr;

    assign w_rd        = cart_enable & ~cart_write;
    assign w_wr        = cart_enable & cart_write;
    assign w_rom_range = ~cart_addr[15];
    assign w_ram_range = (cart_addr[15:13] == 3'b101);
    assign w_ram_ok    = r_ram_en & c_HAS_RAM;

    // In mode 1 the upper bank bits also apply to the fixed 0x0000 window and to RAM.
    assign w_rom_bank = cart_addr[14] ? {r_bank2, r_bank1}
                                      : {(r_mode ? r_bank2 : 2'b00), 5'b00000};
    assign w_ram_bank = r_mode ? r_bank2 : 2'b00;
    assign w_bank1_wr = (cart_wdata[4:0] == 5'd0) ? 5'h01 : cart_wdata[4:0];

    assign rom_addr  = ROM_ADDR_WIDTH'({w_rom_bank, cart_addr[13:0]});
    assign rom_read  = w_rd & w_rom_range;
    assign ram_addr  = c_RAM_AW'({w_ram_bank, cart_addr[12:0]});
    assign ram_read  = w_rd & w_ram_range & w_ram_ok;
    assign ram_write = w_wr & w_ram_range & w_ram_ok;
    assign ram_wdata = cart_wdata;
    assign save_dirty = r_dirty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ram_en <= 1'b0;
            r_bank1  <= 5'h01;
            r_bank2  <= 2'b00;
            r_mode   <= 1'b0;
            r_dirty  <= 1'b0;
        end else begin
            if (w_wr && w_rom_range) begin
                case (cart_addr[14:13])
                    2'd0:    r_ram_en <= (cart_wdata[3:0] == 4'hA);
                    2'd1:    r_bank1  <= w_bank1_wr;
                    2'd2:    r_bank2  <= cart_wdata[1:0];
                    default: r_mode   <= cart_wdata[0];
                endcase
            end
            // A performed write wins over a coincident acknowledge.
            if (ram_write) begin
                r_dirty <= 1'b1;
            end else if (save_ack) begin
                r_dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src <= c_SRC_NONE;
        end else begin
            r_src <= w_src_next;
        end
    end

    always_comb begin
        w_src_next = r_src;
        if (w_rd) begin
            if (w_rom_range) begin
                w_src_next = c_SRC_ROM;
            end else if (w_ram_range && w_ram_ok) begin
                w_src_next = c_SRC_RAM;
            end else begin
                w_src_next = c_SRC_NONE;
            end
        end
    end

    always_comb begin
        cart_rdata = 8'hFF;
        case (r_src)
            c_SRC_ROM: cart_rdata = rom_data;
            c_SRC_RAM: cart_rdata = ram_rdata;
            default:   cart_rdata = 8'hFF;
        endcase
    end

endmodule

`default_nettype wire
